// File: rtl/ceespu_decode_pipe_if.sv
// ---------------------------------------------------------------------------
// ceespu_decode_pipe_if
// Decode -> execute boundary of the ceespu pipeline: the registered control
// and operand bundle plus its valid/ready handshake.
//   master : decode stage (drives O_* bundle and O_valid, samples I_ready)
//   slave  : execute stage (samples O_* bundle and O_valid, drives I_ready)
// Signal names keep the decode stage's point of view (O_ = produced by decode).
// ---------------------------------------------------------------------------
interface ceespu_decode_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 14,
  parameter int RADDR_W = 5
);
  logic               O_valid;
  logic               I_ready;
  logic [DATA_W-1:0]  O_dataA;
  logic [DATA_W-1:0]  O_dataB;
  logic [DATA_W-1:0]  O_storeData;
  logic [3:0]         O_aluop;
  logic [1:0]         O_selCin;
  logic [2:0]         O_selMem;
  logic [2:0]         O_branchOp;
  logic [1:0]         O_selWb;
  logic [RADDR_W-1:0] O_regD;
  logic               O_we;
  logic               O_memE;
  logic               O_memWe;
  logic               O_isBranch;
  logic [PC_W-1:0]    O_PC;
  logic [PC_W-1:0]    O_branchTarget;
  logic               O_illegal;

  modport master (
    output O_valid, O_dataA, O_dataB, O_storeData, O_aluop, O_selCin, O_selMem,
           O_branchOp, O_selWb, O_regD, O_we, O_memE, O_memWe, O_isBranch,
           O_PC, O_branchTarget, O_illegal,
    input  I_ready
  );

  modport slave (
    input  O_valid, O_dataA, O_dataB, O_storeData, O_aluop, O_selCin, O_selMem,
           O_branchOp, O_selWb, O_regD, O_we, O_memE, O_memWe, O_isBranch,
           O_PC, O_branchTarget, O_illegal,
    output I_ready
  );
endinterface

// File: rtl/ceespu_decode_pipe.sv
// ---------------------------------------------------------------------------
// ceespu_decode_pipe
// Decode stage between fetch and execute. Decodes one instruction per cycle,
// builds 32-bit (DATA_W) immediates with an IMM-prefix state machine that
// survives fetch bubbles, and registers the decoded bundle behind a
// valid/ready handshake. Also owns the interrupt-enable flag.
//
// Ports:
//   I_clk, I_rst         clock, asynchronous active-high reset
//   I_flush              synchronous kill of the output bundle and prefix state
//   I_valid / O_ready    fetch-side handshake for I_instruction / I_PC
//   I_regA / I_regB      register file read data for O_regA / O_regB indices
//   O_regA / O_regB      read indices, combinational from I_instruction
//   I_didInterrupt       interrupt taken this cycle (clears the enable flag)
//   bus (master)         decoded bundle + O_valid / I_ready to execute
//   O_intEnabled         interrupt-enable flag
//   O_intSafe            interrupt injection will not split an IMM pair
//
// Instruction layout:
//   [31:28] major opcode  [27] C (carry) bit  [26] IMM-operand bit
//   [25:21] rd  [20:16] ra  [15:11] rb  [15:0] immediate low field
//   Branches: [31:29]=111, [28:26] condition, [1] register target, [0] link.
//   Loads/stores: [27:26] memory size.
//   Stores reuse the rd field as immediate bits: low = {rd, instr[10:0]}.
// ---------------------------------------------------------------------------
module ceespu_decode_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int PC_W    = 14,
  parameter int RADDR_W = 5
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_flush,
  input  logic                I_valid,
  output logic                O_ready,
  input  logic [31:0]         I_instruction,
  input  logic [PC_W-1:0]     I_PC,
  input  logic [DATA_W-1:0]   I_regA,
  input  logic [DATA_W-1:0]   I_regB,
  output logic [RADDR_W-1:0]  O_regA,
  output logic [RADDR_W-1:0]  O_regB,
  input  logic                I_didInterrupt,
  ceespu_decode_pipe_if.master bus,
  output logic                O_intEnabled,
  output logic                O_intSafe
);

  // Major opcodes (instr[31:28]); 11..13 are unassigned and decode as illegal.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHF   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_IMM   = 4'd9;
  localparam logic [3:0] OP_EINT  = 4'd10;
  localparam logic [3:0] OP_BR0   = 4'd14;
  localparam logic [3:0] OP_BR1   = 4'd15;

  // ALU operations. Subtract is an add of ~A with a forced carry-in.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SHF = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;

  // Carry-in select: 0 = 0, 1 = carry flag, 2 = carry flag (borrow), 3 = 1.
  // Writeback select: 0 = ALU, 1 = memory, 2 = link (PC).
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Register holding the return address from an interrupt handler.
  localparam logic [RADDR_W-1:0] REG_IRET = RADDR_W'(17);

  typedef enum logic {S_IDLE, S_PREFIX} pfx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data_a;
    logic [DATA_W-1:0]  data_b;
    logic [DATA_W-1:0]  store_data;
    logic [3:0]         aluop;
    logic [1:0]         sel_cin;
    logic [2:0]         sel_mem;
    logic [2:0]         branch_op;
    logic [1:0]         sel_wb;
    logic [RADDR_W-1:0] reg_d;
    logic               we;
    logic               mem_e;
    logic               mem_we;
    logic               is_branch;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    target;
    logic               illegal;
  } bundle_t;

  pfx_state_t       state_q;
  logic [IMM_W-1:0] imm_hi_q;
  logic             int_en_q;
  logic             valid_q;
  bundle_t          bundle_q;
  bundle_t          bundle_d;

  // Instruction fields
  logic [3:0]         op_hi;
  logic               c_bit;
  logic               imm_bit;
  logic [RADDR_W-1:0] idx_d;
  logic [RADDR_W-1:0] idx_a;
  logic               is_imm_op;
  logic               is_eint_op;
  logic               is_branch_op;
  logic               reg_target;
  logic               accept;

  assign op_hi        = I_instruction[31:28];
  assign c_bit        = I_instruction[27];
  assign imm_bit      = I_instruction[26];
  assign idx_d        = RADDR_W'(I_instruction[25:21]);
  assign idx_a        = RADDR_W'(I_instruction[20:16]);
  assign O_regA       = idx_a;
  assign O_regB       = RADDR_W'(I_instruction[15:11]);
  assign is_imm_op    = (op_hi == OP_IMM);
  assign is_eint_op   = (op_hi == OP_EINT);
  assign is_branch_op = (I_instruction[31:29] == 3'b111);
  assign reg_target   = is_branch_op && I_instruction[1] && (I_instruction[28:26] == 3'd7);

  // Handshake. A flush cycle never accepts, so nothing fetched alongside a
  // flush can leak into the stage or the prefix state.
  assign O_ready = !valid_q || bus.I_ready;
  assign accept  = I_valid && O_ready && !I_flush;

  // An interrupt between an IMM and its consumer would lose imm_hi, so
  // injection is refused both while a prefix is pending and while one is
  // being presented.
  assign O_intSafe    = (state_q == S_IDLE) && !(I_valid && is_imm_op);
  assign O_intEnabled = int_en_q;

  // Immediate formation
  logic [IMM_W-1:0]        imm_lo;
  logic [DATA_W-IMM_W-1:0] imm_hi_ext;
  logic [DATA_W-1:0]       imm;
  logic [DATA_W-1:0]       opnd_b;

  assign imm_lo     = (op_hi == OP_STORE) ? IMM_W'({I_instruction[25:21], I_instruction[10:0]})
                                          : I_instruction[IMM_W-1:0];
  assign imm_hi_ext = (DATA_W-IMM_W)'($signed(imm_hi_q));
  assign imm        = (state_q == S_PREFIX) ? {imm_hi_ext, imm_lo}
                                            : DATA_W'($signed(imm_lo));
  assign opnd_b     = imm_bit ? imm : I_regB;

  // NOTE: every field gets a default before the case so that no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    bundle_d            = '0;
    bundle_d.data_a     = I_regA;
    bundle_d.data_b     = I_regB;
    bundle_d.store_data = I_regB;
    bundle_d.reg_d      = idx_d;
    bundle_d.pc         = I_PC;
    bundle_d.target     = imm[PC_W+1:2];
    case (op_hi)
      OP_ADD: begin
        bundle_d.aluop   = ALU_ADD;
        bundle_d.sel_cin = c_bit ? 2'd1 : 2'd0;
        bundle_d.data_b  = opnd_b;
        bundle_d.we      = 1'b1;
      end
      OP_SUB: begin
        bundle_d.aluop   = ALU_ADD;
        bundle_d.data_a  = ~I_regA;
        bundle_d.sel_cin = c_bit ? 2'd2 : 2'd3;
        bundle_d.data_b  = opnd_b;
        bundle_d.we      = 1'b1;
      end
      OP_OR:  begin bundle_d.aluop = ALU_OR;  bundle_d.data_b = opnd_b; bundle_d.we = 1'b1; end
      OP_AND: begin bundle_d.aluop = ALU_AND; bundle_d.data_b = opnd_b; bundle_d.we = 1'b1; end
      OP_XOR: begin bundle_d.aluop = ALU_XOR; bundle_d.data_b = opnd_b; bundle_d.we = 1'b1; end
      OP_SHF: begin bundle_d.aluop = ALU_SHF; bundle_d.data_b = opnd_b; bundle_d.we = 1'b1; end
      OP_MUL: begin bundle_d.aluop = ALU_MUL; bundle_d.data_b = opnd_b; bundle_d.we = 1'b1; end
      OP_LOAD: begin
        bundle_d.aluop   = ALU_ADD;
        bundle_d.sel_mem = {1'b0, I_instruction[27:26]};
        bundle_d.sel_wb  = WB_MEM;
        bundle_d.mem_e   = 1'b1;
        bundle_d.data_b  = imm;
        bundle_d.we      = 1'b1;
      end
      OP_STORE: begin
        bundle_d.aluop   = ALU_ADD;
        bundle_d.sel_mem = {1'b0, I_instruction[27:26]};
        bundle_d.mem_e   = 1'b1;
        bundle_d.mem_we  = 1'b1;
        bundle_d.data_b  = imm;
      end
      OP_IMM, OP_EINT: ;  // no architectural effect in execute
      OP_BR0, OP_BR1: begin
        bundle_d.is_branch = 1'b1;
        bundle_d.branch_op = I_instruction[28:26];
        bundle_d.reg_d     = idx_a;
        bundle_d.we        = I_instruction[0];
        bundle_d.sel_wb    = I_instruction[0] ? WB_LINK : WB_ALU;
        if (reg_target) bundle_d.target = I_regA[PC_W+1:2];
      end
      default: bundle_d.illegal = 1'b1;
    endcase
    if (bundle_d.reg_d == '0) bundle_d.we = 1'b0;  // r0 is hard-wired zero
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      imm_hi_q <= '0;
      int_en_q <= 1'b1;
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      if (I_didInterrupt)
        int_en_q <= 1'b0;
      else if (accept && is_eint_op)
        int_en_q <= I_instruction[0];
      else if (accept && reg_target && idx_a == REG_IRET)
        int_en_q <= 1'b1;  // return from interrupt re-enables

      if (I_flush) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
      end else if (accept) begin
        if (is_imm_op) begin
          // Prefix yields no bundle; a bundle being taken this cycle retires.
          imm_hi_q <= I_instruction[IMM_W-1:0];
          state_q  <= S_PREFIX;
          valid_q  <= 1'b0;
        end else begin
          state_q  <= S_IDLE;
          valid_q  <= 1'b1;
          bundle_q <= bundle_d;
        end
      end else if (bus.I_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.O_valid        = valid_q;
  assign bus.O_dataA        = bundle_q.data_a;
  assign bus.O_dataB        = bundle_q.data_b;
  assign bus.O_storeData    = bundle_q.store_data;
  assign bus.O_aluop        = bundle_q.aluop;
  assign bus.O_selCin       = bundle_q.sel_cin;
  assign bus.O_selMem       = bundle_q.sel_mem;
  assign bus.O_branchOp     = bundle_q.branch_op;
  assign bus.O_selWb        = bundle_q.sel_wb;
  assign bus.O_regD         = bundle_q.reg_d;
  assign bus.O_we           = bundle_q.we;
  assign bus.O_memE         = bundle_q.mem_e;
  assign bus.O_memWe        = bundle_q.mem_we;
  assign bus.O_isBranch     = bundle_q.is_branch;
  assign bus.O_PC           = bundle_q.pc;
  assign bus.O_branchTarget = bundle_q.target;
  assign bus.O_illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_ceespu_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_ceespu_decode_pipe
// Directed bench for ceespu_decode_pipe: a 32-bit instance under full test
// and a 64-bit instance sharing the fetch-side stimulus (always ready) for the
// wide-immediate sign extension case. Outputs are sampled 1 ns after the
// rising edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_ceespu_decode_pipe;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_flush;
  logic        I_valid;
  logic        O_ready;
  logic [31:0] I_instruction;
  logic [13:0] I_PC;
  logic [31:0] I_regA;
  logic [31:0] I_regB;
  logic [4:0]  O_regA;
  logic [4:0]  O_regB;
  logic        I_didInterrupt;
  logic        O_intEnabled;
  logic        O_intSafe;

  logic [63:0] regA64;
  logic [63:0] regB64;
  logic        O_ready64;
  logic [4:0]  O_regA64;
  logic [4:0]  O_regB64;
  logic        O_intEnabled64;
  logic        O_intSafe64;

  int checks   = 0;
  int failures = 0;

  ceespu_decode_pipe_if #(.DATA_W(32), .PC_W(14), .RADDR_W(5)) bus ();
  ceespu_decode_pipe_if #(.DATA_W(64), .PC_W(14), .RADDR_W(5)) bus64 ();

  ceespu_decode_pipe #(.DATA_W(32), .IMM_W(16), .PC_W(14), .RADDR_W(5)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_flush(I_flush), .I_valid(I_valid),
    .O_ready(O_ready), .I_instruction(I_instruction), .I_PC(I_PC),
    .I_regA(I_regA), .I_regB(I_regB), .O_regA(O_regA), .O_regB(O_regB),
    .I_didInterrupt(I_didInterrupt), .bus(bus),
    .O_intEnabled(O_intEnabled), .O_intSafe(O_intSafe)
  );

  ceespu_decode_pipe #(.DATA_W(64), .IMM_W(16), .PC_W(14), .RADDR_W(5)) dut64 (
    .I_clk(I_clk), .I_rst(I_rst), .I_flush(I_flush), .I_valid(I_valid),
    .O_ready(O_ready64), .I_instruction(I_instruction), .I_PC(I_PC),
    .I_regA(regA64), .I_regB(regB64), .O_regA(O_regA64), .O_regB(O_regB64),
    .I_didInterrupt(I_didInterrupt), .bus(bus64),
    .O_intEnabled(O_intEnabled64), .O_intSafe(O_intSafe64)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [13:0] pc);
    I_valid       = 1'b1;
    I_instruction = instr;
    I_regA        = ra;
    I_regB        = rb;
    I_PC          = pc;
    #1;
  endtask

  task automatic idle();
    I_valid       = 1'b0;
    I_instruction = '0;
    #1;
  endtask

  task automatic test_reset();
    I_rst = 1'b1; I_flush = 1'b0; I_valid = 1'b0; I_instruction = '0; I_PC = '0;
    I_regA = '0; I_regB = '0; I_didInterrupt = 1'b0; regA64 = '0; regB64 = '0;
    bus.I_ready = 1'b1; bus64.I_ready = 1'b1;
    #12;
    I_rst = 1'b0;
    step();
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.O_valid); end
    checks++; if (O_intEnabled !== 1'b1) begin failures++; $display("FAIL reset_intEnabled got=%b exp=1", O_intEnabled); end
    checks++; if (O_intSafe !== 1'b1) begin failures++; $display("FAIL reset_intSafe got=%b exp=1", O_intSafe); end
    checks++; if (O_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", O_ready); end
    checks++; if (bus.O_dataB !== 32'h0 || bus.O_we !== 1'b0) begin failures++; $display("FAIL reset_bundle dataB=%h we=%b exp=0/0", bus.O_dataB, bus.O_we); end
  endtask

  task automatic test_prefix();
    drive({4'd9, 2'b00, 10'd0, 16'h1234}, 32'd0, 32'd0, 14'h0);          // IMM 0x1234
    checks++; if (O_intSafe !== 1'b0) begin failures++; $display("FAIL prefix_safe_on_imm got=%b exp=0", O_intSafe); end
    step();
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL prefix_imm_no_bundle got=%b exp=0", bus.O_valid); end
    drive({4'd0, 1'b0, 1'b1, 5'd3, 5'd1, 16'h5678}, 32'd1, 32'd0, 14'h1);  // ADDI r3,r1,0x5678
    checks++; if (O_intSafe !== 1'b0) begin failures++; $display("FAIL prefix_safe_pending got=%b exp=0", O_intSafe); end
    step();
    checks++; if (bus.O_valid !== 1'b1) begin failures++; $display("FAIL prefix_valid got=%b exp=1", bus.O_valid); end
    checks++; if (bus.O_dataB !== 32'h12345678) begin failures++; $display("FAIL prefix_dataB got=%h exp=12345678", bus.O_dataB); end
    checks++; if (bus.O_dataA !== 32'h1) begin failures++; $display("FAIL prefix_dataA got=%h exp=1", bus.O_dataA); end
    checks++; if (bus.O_we !== 1'b1 || bus.O_regD !== 5'd3) begin failures++; $display("FAIL prefix_wb we=%b regD=%0d exp=1/3", bus.O_we, bus.O_regD); end
    idle();
    checks++; if (O_intSafe !== 1'b1) begin failures++; $display("FAIL prefix_back_to_idle got=%b exp=1", O_intSafe); end
    step();
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL prefix_valid_drop got=%b exp=0", bus.O_valid); end
  endtask

  task automatic test_bubbles();
    drive({4'd9, 2'b00, 10'd0, 16'hABCD}, 32'd0, 32'd0, 14'h2);           // IMM 0xABCD
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (O_intSafe !== 1'b0 || bus.O_valid !== 1'b0) begin failures++; $display("FAIL bubble_%0d safe=%b valid=%b exp=0/0", i, O_intSafe, bus.O_valid); end
      step();
    end
    drive({4'd2, 1'b0, 1'b1, 5'd4, 5'd2, 16'h0001}, 32'd0, 32'd0, 14'h3); // ORI r4,r2,1
    step();
    checks++; if (bus.O_dataB !== 32'hABCD0001) begin failures++; $display("FAIL bubble_dataB got=%h exp=abcd0001", bus.O_dataB); end
    checks++; if (bus.O_aluop !== 4'd1 || bus.O_regD !== 5'd4) begin failures++; $display("FAIL bubble_ctrl aluop=%0d regD=%0d exp=1/4", bus.O_aluop, bus.O_regD); end
    idle();
    step();
  endtask

  task automatic test_sign_ext();
    drive({4'd0, 1'b0, 1'b1, 5'd5, 5'd0, 16'hFFF0}, 32'd0, 32'd0, 14'h4); // ADDI r5,r0,0xFFF0
    step();
    checks++; if (bus.O_dataB !== 32'hFFFFFFF0) begin failures++; $display("FAIL sext_dataB got=%h exp=fffffff0", bus.O_dataB); end
    checks++; if (bus64.O_dataB !== 64'hFFFFFFFF_FFFFFFF0) begin failures++; $display("FAIL sext64_dataB got=%h exp=fffffffffffffff0", bus64.O_dataB); end
    drive({4'd9, 2'b00, 10'd0, 16'h8000}, 32'd0, 32'd0, 14'h5);           // IMM 0x8000
    step();
    drive({4'd0, 1'b0, 1'b1, 5'd5, 5'd0, 16'h0000}, 32'd0, 32'd0, 14'h6); // ADDI r5,r0,0
    step();
    checks++; if (bus.O_dataB !== 32'h80000000) begin failures++; $display("FAIL sext_prefix_dataB got=%h exp=80000000", bus.O_dataB); end
    checks++; if (bus64.O_dataB !== 64'hFFFFFFFF_80000000) begin failures++; $display("FAIL sext64_prefix_dataB got=%h exp=ffffffff80000000", bus64.O_dataB); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive({4'd0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd2, 11'd0}, 32'h11, 32'h22, 14'h10); // ADD r6,r1,r2
    step();
    bus.I_ready = 1'b0;
    drive({4'd4, 1'b0, 1'b0, 5'd7, 5'd3, 5'd4, 11'd0}, 32'h33, 32'h44, 14'h11); // XOR r7,r3,r4
    for (int i = 0; i < 2; i++) begin
      checks++; if (O_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=0", i, O_ready); end
      step();
      checks++; if (bus.O_valid !== 1'b1 || bus.O_dataA !== 32'h11 || bus.O_dataB !== 32'h22 || bus.O_PC !== 14'h10)
        begin failures++; $display("FAIL b2b_hold_%0d valid=%b dataA=%h dataB=%h pc=%h exp=1/11/22/10", i, bus.O_valid, bus.O_dataA, bus.O_dataB, bus.O_PC); end
    end
    bus.I_ready = 1'b1;
    #1;
    checks++; if (O_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_release got=%b exp=1", O_ready); end
    step();
    checks++; if (bus.O_valid !== 1'b1 || bus.O_dataA !== 32'h33 || bus.O_dataB !== 32'h44 || bus.O_PC !== 14'h11)
      begin failures++; $display("FAIL b2b_second valid=%b dataA=%h dataB=%h pc=%h exp=1/33/44/11", bus.O_valid, bus.O_dataA, bus.O_dataB, bus.O_PC); end
    checks++; if (bus.O_aluop !== 4'd3 || bus.O_regD !== 5'd7) begin failures++; $display("FAIL b2b_second_ctrl aluop=%0d regD=%0d exp=3/7", bus.O_aluop, bus.O_regD); end
    idle();
    step();
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", bus.O_valid); end
  endtask

  task automatic test_decode_misc();
    drive({4'd1, 1'b0, 1'b1, 5'd8, 5'd1, 16'h0005}, 32'h3, 32'h0, 14'h20); // SUBI r8,r1,5
    step();
    checks++; if (bus.O_dataA !== 32'hFFFFFFFC || bus.O_dataB !== 32'h5 || bus.O_selCin !== 2'd3)
      begin failures++; $display("FAIL sub dataA=%h dataB=%h selCin=%0d exp=fffffffc/5/3", bus.O_dataA, bus.O_dataB, bus.O_selCin); end
    drive({4'd8, 2'b01, 5'b00010, 5'd3, 5'd4, 11'h005}, 32'h100, 32'hCAFE, 14'h21); // STORE half
    checks++; if (O_regA !== 5'd3 || O_regB !== 5'd4) begin failures++; $display("FAIL store_rdidx regA=%0d regB=%0d exp=3/4", O_regA, O_regB); end
    step();
    checks++; if (bus.O_dataB !== 32'h1005 || bus.O_storeData !== 32'hCAFE)
      begin failures++; $display("FAIL store_data dataB=%h storeData=%h exp=1005/cafe", bus.O_dataB, bus.O_storeData); end
    checks++; if (bus.O_memE !== 1'b1 || bus.O_memWe !== 1'b1 || bus.O_we !== 1'b0 || bus.O_selMem !== 3'd1)
      begin failures++; $display("FAIL store_ctrl memE=%b memWe=%b we=%b selMem=%0d exp=1/1/0/1", bus.O_memE, bus.O_memWe, bus.O_we, bus.O_selMem); end
    drive({4'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 11'd0}, 32'h1, 32'h2, 14'h22); // ADD r0 -> no write
    step();
    checks++; if (bus.O_we !== 1'b0) begin failures++; $display("FAIL r0_we got=%b exp=0", bus.O_we); end
    drive({4'd11, 2'b00, 5'd5, 5'd1, 16'h0000}, 32'h0, 32'h0, 14'h23);     // unassigned opcode
    step();
    checks++; if (bus.O_valid !== 1'b1 || bus.O_illegal !== 1'b1 || bus.O_we !== 1'b0 || bus.O_memE !== 1'b0 || bus.O_isBranch !== 1'b0)
      begin failures++; $display("FAIL illegal valid=%b ill=%b we=%b memE=%b br=%b exp=1/1/0/0/0", bus.O_valid, bus.O_illegal, bus.O_we, bus.O_memE, bus.O_isBranch); end
    drive({3'b111, 3'b000, 5'd0, 5'd9, 16'h0041}, 32'h0, 32'h0, 14'h24);   // BEQ imm target, link
    step();
    checks++; if (bus.O_isBranch !== 1'b1 || bus.O_branchTarget !== 14'h10 || bus.O_we !== 1'b1 || bus.O_regD !== 5'd9 || bus.O_selWb !== 2'd2)
      begin failures++; $display("FAIL br_imm br=%b tgt=%h we=%b regD=%0d selWb=%0d exp=1/10/1/9/2", bus.O_isBranch, bus.O_branchTarget, bus.O_we, bus.O_regD, bus.O_selWb); end
    idle();
    step();
  endtask

  task automatic test_interrupt();
    drive({4'd10, 27'd0, 1'b1}, 32'h0, 32'h0, 14'h30);                    // EINT(1) with interrupt
    I_didInterrupt = 1'b1;
    step();
    I_didInterrupt = 1'b0;
    checks++; if (O_intEnabled !== 1'b0) begin failures++; $display("FAIL int_priority got=%b exp=0", O_intEnabled); end
    drive({3'b111, 3'b111, 5'd0, 5'd17, 14'd0, 1'b1, 1'b0}, 32'h0000ABCC, 32'h0, 14'h31); // B r17
    step();
    checks++; if (O_intEnabled !== 1'b1) begin failures++; $display("FAIL int_iret got=%b exp=1", O_intEnabled); end
    checks++; if (bus.O_branchTarget !== 14'h2AF3 || bus.O_isBranch !== 1'b1 || bus.O_branchOp !== 3'd7 || bus.O_we !== 1'b0)
      begin failures++; $display("FAIL br_reg tgt=%h br=%b op=%0d we=%b exp=2af3/1/7/0", bus.O_branchTarget, bus.O_isBranch, bus.O_branchOp, bus.O_we); end
    drive({4'd10, 27'd0, 1'b0}, 32'h0, 32'h0, 14'h32);                    // EINT(0) with interrupt
    I_didInterrupt = 1'b1;
    step();
    I_didInterrupt = 1'b0;
    checks++; if (O_intEnabled !== 1'b0) begin failures++; $display("FAIL int_eint0 got=%b exp=0", O_intEnabled); end
    drive({4'd10, 27'd0, 1'b1}, 32'h0, 32'h0, 14'h33);                    // EINT(1)
    step();
    checks++; if (O_intEnabled !== 1'b1) begin failures++; $display("FAIL int_eint1 got=%b exp=1", O_intEnabled); end
    idle();
    step();
  endtask

  task automatic test_flush_reset();
    drive({4'd9, 2'b00, 10'd0, 16'h7777}, 32'h0, 32'h0, 14'h40);          // IMM 0x7777
    step();
    idle();
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    #1;
    checks++; if (O_intSafe !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b exp=1", O_intSafe); end
    drive({4'd0, 1'b0, 1'b1, 5'd5, 5'd0, 16'h0010}, 32'h0, 32'h0, 14'h41); // ADDI 0x10
    step();
    checks++; if (bus.O_dataB !== 32'h10) begin failures++; $display("FAIL flush_dataB got=%h exp=10", bus.O_dataB); end
    bus.I_ready = 1'b0;
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    bus.I_ready = 1'b1;
    checks++; if (bus.O_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%b exp=0", bus.O_valid); end
    drive({4'd10, 27'd0, 1'b0}, 32'h0, 32'h0, 14'h42);                    // EINT(0)
    step();
    checks++; if (O_intEnabled !== 1'b0) begin failures++; $display("FAIL pre_reset_int got=%b exp=0", O_intEnabled); end
    drive({4'd0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd2, 11'd0}, 32'h5, 32'h6, 14'h43);
    step();
    I_rst = 1'b1;
    #1;
    checks++; if (bus.O_valid !== 1'b0 || O_intEnabled !== 1'b1) begin failures++; $display("FAIL async_reset valid=%b int=%b exp=0/1", bus.O_valid, O_intEnabled); end
    #1;
    I_rst = 1'b0;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_prefix();
    test_bubbles();
    test_sign_ext();
    test_back_to_back();
    test_decode_misc();
    test_interrupt();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
